// File: rtl/rf_param_bypass_if.sv
// Register file port bundle: decode-side reads, writeback-side write, read data back.
interface rf_param_bypass_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) ();
    logic              read_enabled;
    logic [ADDR_W-1:0] read_addr_s;
    logic [ADDR_W-1:0] read_addr_t;
    logic              write_enabled;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] outA;
    logic [DATA_W-1:0] outB;
    logic              ready;

    // Datapath side drives addresses and write data.
    modport master (
        output read_enabled, read_addr_s, read_addr_t,
        output write_enabled, write_addr, write_data,
        input  outA, outB, ready
    );

    // Register file side.
    modport slave (
        input  read_enabled, read_addr_s, read_addr_t,
        input  write_enabled, write_addr, write_data,
        output outA, outB, ready
    );
endinterface

// File: rtl/rf_param_bypass.sv
// Parametrised 2-read/1-write register file with sequenced clear,
// optional hardwired zero entry and optional write-to-read forwarding.
module rf_param_bypass #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    rf_param_bypass_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    // One extra bit so the counter can represent DEPTH without wrapping.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic              ready_q;

    logic [DATA_W-1:0] rd_a_c;
    logic [DATA_W-1:0] rd_b_c;
    logic              wr_ok_c;

    // Read value for one port: zero entry first, then forwarding, then stored contents.
    function automatic logic [DATA_W-1:0] rd_sel(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (ZERO_REG && (a == '0)) return '0;
        if (BYPASS && we && (wa == a)) return wd;
        return stored;
    endfunction

    // Read muxes and write qualification.
    always_comb begin
        rd_a_c  = rd_sel(bus.read_addr_s, mem[bus.read_addr_s],
                         bus.write_enabled, bus.write_addr, bus.write_data);
        rd_b_c  = rd_sel(bus.read_addr_t, mem[bus.read_addr_t],
                         bus.write_enabled, bus.write_addr, bus.write_data);
        wr_ok_c = (state == ST_RUN) && bus.write_enabled &&
                  !(ZERO_REG && (bus.write_addr == '0));
    end

    // Storage: zeroed one entry per cycle while clearing, written by writeback when running.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt[ADDR_W-1:0]] <= '0;
            end else if (wr_ok_c) begin
                mem[bus.write_addr] <= bus.write_data;
            end
        end
    end

    // Control FSM with registered read data and ready flag; reset dominates.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            ready_q <= 1'b0;
            out_a   <= '0;
            out_b   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + CNT_W'(1);
                    if (clr_cnt == LAST_IDX) begin
                        state   <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.read_enabled) begin
                        out_a <= rd_a_c;
                        out_b <= rd_b_c;
                    end
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

    assign bus.outA  = out_a;
    assign bus.outB  = out_b;
    assign bus.ready = ready_q;

endmodule

// File: tb/tb_rf_param_bypass.sv
// Bench for rf_param_bypass: two builds (forwarding+zero entry, plain) driven
// in lockstep and compared against an array-based reference model.
module tb_rf_param_bypass;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NREG  = 32;

    logic          clock;
    logic          tb_rst;
    logic          tb_re;
    logic [AW-1:0] tb_s;
    logic [AW-1:0] tb_t;
    logic          tb_we;
    logic [AW-1:0] tb_wa;
    logic [DW-1:0] tb_wd;

    int total;
    int bad;

    // Build 0: ZERO_REG=1, BYPASS=1. Build 1: ZERO_REG=0, BYPASS=0.
    rf_param_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    rf_param_bypass_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    assign bus0.read_enabled  = tb_re;
    assign bus0.read_addr_s   = tb_s;
    assign bus0.read_addr_t   = tb_t;
    assign bus0.write_enabled = tb_we;
    assign bus0.write_addr    = tb_wa;
    assign bus0.write_data    = tb_wd;
    assign bus1.read_enabled  = tb_re;
    assign bus1.read_addr_s   = tb_s;
    assign bus1.read_addr_t   = tb_t;
    assign bus1.write_enabled = tb_we;
    assign bus1.write_addr    = tb_wa;
    assign bus1.write_data    = tb_wd;

    rf_param_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
        .clock (clock),
        .reset (tb_rst),
        .bus   (bus0)
    );

    rf_param_bypass #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut1 (
        .clock (clock),
        .reset (tb_rst),
        .bus   (bus1)
    );

    always #5 clock = ~clock;

    // Reference model state, one copy per build.
    logic [DW-1:0] mdl_mem [2][NREG];
    logic          mdl_ready [2];
    int            mdl_edges [2];
    logic [DW-1:0] mdl_a [2];
    logic [DW-1:0] mdl_b [2];

    function automatic logic has_zero(input int k);
        return (k == 0);
    endfunction

    function automatic logic has_bypass(input int k);
        return (k == 0);
    endfunction

    function automatic logic [DW-1:0] mdl_rd(input int k, input logic [AW-1:0] a,
                                              input logic we, input logic [AW-1:0] wa,
                                              input logic [DW-1:0] wd);
        if (has_zero(k) && a == 0) return '0;
        if (has_bypass(k) && we && wa == a) return wd;
        return mdl_mem[k][a];
    endfunction

    // Advance the model by one clock edge using the inputs held across it.
    task automatic mdl_edge();
        logic [DW-1:0] na;
        logic [DW-1:0] nb;
        for (int k = 0; k < 2; k++) begin
            if (tb_rst) begin
                mdl_ready[k] = 1'b0;
                mdl_edges[k] = 0;
                mdl_a[k]     = '0;
                mdl_b[k]     = '0;
            end else if (!mdl_ready[k]) begin
                // Ready follows DEPTH clearing edges; everything is zero afterwards.
                mdl_edges[k] = mdl_edges[k] + 1;
                if (mdl_edges[k] == int'(NREG)) begin
                    mdl_ready[k] = 1'b1;
                    for (int r = 0; r < int'(NREG); r++) mdl_mem[k][r] = '0;
                end
            end else begin
                na = mdl_rd(k, tb_s, tb_we, tb_wa, tb_wd);
                nb = mdl_rd(k, tb_t, tb_we, tb_wa, tb_wd);
                if (tb_re) begin
                    mdl_a[k] = na;
                    mdl_b[k] = nb;
                end
                if (tb_we && !(has_zero(k) && tb_wa == 0)) mdl_mem[k][tb_wa] = tb_wd;
            end
        end
    endtask

    task automatic check(input string tag, input int k, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s[build%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // One directed clock step: drive, take the edge, update model, compare.
    task automatic step(input logic rst, input logic re, input logic [AW-1:0] s,
                        input logic [AW-1:0] t, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd);
        tb_rst = rst;
        tb_re  = re;
        tb_s   = s;
        tb_t   = t;
        tb_we  = we;
        tb_wa  = wa;
        tb_wd  = wd;
        @(posedge clock);
        mdl_edge();
        #1;
        check("ready", 0, DW'(bus0.ready), DW'(mdl_ready[0]));
        check("outA",  0, bus0.outA, mdl_a[0]);
        check("outB",  0, bus0.outB, mdl_b[0]);
        check("ready", 1, DW'(bus1.ready), DW'(mdl_ready[1]));
        check("outA",  1, bus1.outA, mdl_a[1]);
        check("outB",  1, bus1.outB, mdl_b[1]);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic rand_clear_step();
        step(1'b0, 1'($urandom), AW'($urandom), AW'($urandom),
             1'($urandom), AW'($urandom), DW'($urandom));
    endtask

    initial begin
        clock  = 1'b0;
        total  = 0;
        bad    = 0;
        tb_rst = 1'b1;
        tb_re  = 1'b0;
        tb_s   = '0;
        tb_t   = '0;
        tb_we  = 1'b0;
        tb_wa  = '0;
        tb_wd  = '0;
        for (int k = 0; k < 2; k++) begin
            mdl_ready[k] = 1'b0;
            mdl_edges[k] = 0;
            mdl_a[k]     = '0;
            mdl_b[k]     = '0;
            for (int r = 0; r < int'(NREG); r++) mdl_mem[k][r] = '0;
        end

        // Reset one cycle, then the clear sequence with random traffic that must be ignored.
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < int'(NREG); i++) rand_clear_step();

        // Every entry reads zero after the clear.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, AW'(i), AW'(i + 16), 1'b0, '0, '0);

        // Write r5, read it on both ports.
        step(1'b0, 1'b0, '0, '0, 1'b1, AW'(5), 32'hDEADBEEF);
        step(1'b0, 1'b1, AW'(5), AW'(5), 1'b0, '0, '0);

        // Same-edge write and read of r7: forwarded only in build 0.
        step(1'b0, 1'b1, AW'(7), AW'(5), 1'b1, AW'(7), 32'h12345678);
        step(1'b0, 1'b1, AW'(7), AW'(7), 1'b0, '0, '0);

        // Write r0 with a same-edge read, then a read on port B.
        step(1'b0, 1'b1, AW'(0), AW'(5), 1'b1, AW'(0), 32'hFFFFFFFF);
        step(1'b0, 1'b1, AW'(5), AW'(0), 1'b0, '0, '0);

        // Hold: load A5A5A5A5, then change address and write it with reads disabled.
        step(1'b0, 1'b0, '0, '0, 1'b1, AW'(9), 32'hA5A5A5A5);
        step(1'b0, 1'b1, AW'(9), AW'(9), 1'b0, '0, '0);
        step(1'b0, 1'b0, AW'(10), AW'(11), 1'b1, AW'(10), 32'h0BADF00D);
        step(1'b0, 1'b0, AW'(10), AW'(10), 1'b1, AW'(9), 32'h11111111);
        step(1'b0, 1'b1, AW'(10), AW'(9), 1'b0, '0, '0);

        // Reset again, interrupt the clear at cycle 10, write r3 during the restarted clear.
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) rand_clear_step();
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 0; i < int'(NREG); i++) begin
            if (i == 4) step(1'b0, 1'b1, AW'(3), AW'(3), 1'b1, AW'(3), 32'hCAFEF00D);
            else        idle();
        end
        step(1'b0, 1'b1, AW'(3), AW'(10), 1'b0, '0, '0);

        // Random traffic in RUN with rare resets.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 149) == 0), 1'($urandom), AW'($urandom),
                 AW'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), DW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
